// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with a fixed-latency word-addressed data RAM.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic        err
);
  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic is_lw_q, is_lw_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0] dest_q, dest_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0] out_dest_q, out_dest_d;
  logic out_we_q, out_we_d, err_q, err_d;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic acc, is_ls, mem_done;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == RESP;
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;
  assign out_we    = out_we_q;
  assign err       = err_q;
  assign acc       = in_valid && in_ready;
  assign is_ls     = op == OP_LW || op == OP_SW;
  assign mem_done  = state_q == ACCESS && cnt_q == 4'd0;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_lw_d    = is_lw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dest_d     = dest_q;
    out_data_d = out_data_q;
    out_dest_d = out_dest_q;
    out_we_d   = out_we_q;
    err_d      = err_q;
    if (acc) begin
      is_lw_d = op == OP_LW;
      addr_d  = alu_result[DEPTH_LOG2+1:2];
      wdata_d = store_data;
      dest_d  = dest_reg;
      if (is_ls && alu_result[1:0] == 2'b00) begin
        state_d = ACCESS;
        cnt_d   = LAT_M1;
      end else begin
        state_d    = RESP;
        out_data_d = alu_result;
        out_dest_d = dest_reg;
        out_we_d   = op == OP_R;
        err_d      = is_ls;
      end
    end else if (mem_done) begin
      // lw data is read here, after any earlier sw has already committed
      state_d    = RESP;
      out_data_d = is_lw_q ? mem[addr_q] : wdata_q;
      out_dest_d = dest_q;
      out_we_d   = is_lw_q;
      err_d      = 1'b0;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_lw_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
      out_data_q <= '0;
      out_dest_q <= '0;
      out_we_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_lw_q    <= is_lw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dest_q     <= dest_d;
      out_data_q <= out_data_d;
      out_dest_q <= out_dest_d;
      out_we_q   <= out_we_d;
      err_q      <= err_d;
    end
  end
  // state_q clears asynchronously, so a reset during ACCESS also kills the write
  always_ff @(posedge clk) begin
    if (mem_done && !is_lw_q) mem[addr_q] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (DEPTH_LOG2=8, LATENCY=2).
module tb_mem_stage;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [5:0] op = '0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [4:0] dest_reg = '0;
  logic out_valid, out_we, err;
  logic [31:0] out_data;
  logic [4:0] out_dest;
  int errors = 0, checks = 0, lat = 0;
  logic pulsed;

  mem_stage #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest), .out_we(out_we), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [5:0] o, input logic [31:0] a, input logic [31:0] s,
                     input logic [4:0] d, output int l);
    @(negedge clk);
    in_valid = 1'b1; op = o; alu_result = a; store_data = s; dest_reg = d;
    @(posedge clk);
    #1 in_valid = 1'b0; op = OP_R; alu_result = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF; dest_reg = 5'd31;
    l = 0;
    while (l < 20) begin
      @(negedge clk);
      l++;
      if (out_valid) break;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_we", out_we, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    txn(OP_R, 32'h0000_002A, 32'h0, 5'd5, lat);
    chk("rt_lat", lat, 1);
    chk("rt_data", out_data, 32'h2A);
    chk("rt_dest", out_dest, 5);
    chk("rt_we", out_we, 1);
    chk("rt_err", err, 0);
    chk("rt_busy", in_ready, 0);
    @(negedge clk);
    chk("rt_ready_back", in_ready, 1);
    chk("rt_valid_drop", out_valid, 0);

    txn(OP_SW, 32'h10, 32'hDEAD_BEEF, 5'd2, lat);
    chk("sw_lat", lat, 3);
    chk("sw_we", out_we, 0);
    chk("sw_err", err, 0);
    txn(OP_LW, 32'h10, 32'h0, 5'd7, lat);
    chk("lw_lat", lat, 3);
    chk("lw_data", out_data, 32'hDEAD_BEEF);
    chk("lw_dest", out_dest, 7);
    chk("lw_we", out_we, 1);

    txn(OP_SW, 32'h400, 32'h1234, 5'd1, lat);
    chk("wrap_sw_lat", lat, 3);
    txn(OP_LW, 32'h000, 32'h0, 5'd8, lat);
    chk("wrap_lw_lat", lat, 3);
    chk("wrap_lw_data", out_data, 32'h1234);

    txn(OP_LW, 32'h13, 32'h0, 5'd9, lat);
    chk("mis_lw_lat", lat, 1);
    chk("mis_lw_err", err, 1);
    chk("mis_lw_we", out_we, 0);
    chk("mis_lw_data", out_data, 32'h13);
    @(negedge clk);
    chk("hold_data", out_data, 32'h13);
    chk("hold_err", err, 1);
    txn(OP_SW, 32'h12, 32'h0000_0BAD, 5'd9, lat);
    chk("mis_sw_lat", lat, 1);
    chk("mis_sw_err", err, 1);
    txn(OP_LW, 32'h10, 32'h0, 5'd10, lat);
    chk("mis_mem_intact", out_data, 32'hDEAD_BEEF);
    chk("aligned_err_clr", err, 0);

    @(negedge clk);
    in_valid = 1'b1; op = OP_BEQ; alu_result = 32'h1; dest_reg = 5'd4;
    @(posedge clk);
    #1 op = OP_R; alu_result = 32'h77; dest_reg = 5'd9;
    @(negedge clk);
    chk("beq_valid", out_valid, 1);
    chk("beq_we", out_we, 0);
    chk("beq_data", out_data, 32'h1);
    chk("beq_busy", in_ready, 0);
    @(negedge clk);
    chk("held_ignored", out_valid, 0);
    chk("held_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_rt_valid", out_valid, 1);
    chk("held_rt_data", out_data, 32'h77);
    chk("held_rt_dest", out_dest, 9);
    chk("held_rt_we", out_we, 1);

    txn(OP_SW, 32'h20, 32'h55AA_1234, 5'd3, lat);
    chk("pre_sw_lat", lat, 3);
    @(negedge clk);
    in_valid = 1'b1; op = OP_SW; alu_result = 32'h20; store_data = 32'hCAFE_F00D; dest_reg = 5'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_idle", in_ready, 1);
    pulsed = out_valid;
    repeat (2) begin @(negedge clk); pulsed |= out_valid; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); pulsed |= out_valid; end
    chk("abort_no_resp", pulsed, 0);
    chk("abort_we_rst", out_we, 0);
    txn(OP_LW, 32'h20, 32'h0, 5'd11, lat);
    chk("abort_lw_lat", lat, 3);
    chk("abort_mem_kept", out_data, 32'h55AA_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
